// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: definitions shared by the memory arbiter, its interface and
// its bench.
//   - XLEN / ADDR_W / DATA_W    : 32-bit address and data widths
//   - REQUIRE8/16/32            : lsb_len codes (3 is illegal and behaves as a word)
//   - IO_SEL                    : addr[17:16] value that selects the UART window (0x30000)
//   - arb_state_e               : FSM state encoding (also visible on state_dbg)
//   - len_to_bytes / is_io_sel  : small decode helpers
package mem_arbiter_pkg;

  localparam int XLEN   = 32;
  localparam int ADDR_W = XLEN;
  localparam int DATA_W = XLEN;

  localparam logic [1:0] REQUIRE8  = 2'd0;
  localparam logic [1:0] REQUIRE16 = 2'd1;
  localparam logic [1:0] REQUIRE32 = 2'd2;

  localparam logic [1:0] IO_SEL = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_LOAD  = 2'd2,
    ST_STORE = 2'd3
  } arb_state_e;

  // Byte count of a transaction; the illegal code 3 is served as a word.
  function automatic logic [2:0] len_to_bytes(input logic [1:0] len);
    case (len)
      REQUIRE8:  len_to_bytes = 3'd1;
      REQUIRE16: len_to_bytes = 3'd2;
      default:   len_to_bytes = 3'd4;
    endcase
  endfunction

  // Takes addr[17:16] only, so callers slice the address themselves.
  function automatic logic is_io_sel(input logic [1:0] sel);
    is_io_sel = (sel == IO_SEL);
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: bundles every non-clock signal of the memory arbiter.
//   Control    : rdy (global enable), jump_wrong (flush), io_buffer_full
//   Fetch      : if_req, if_addr -> if_done, if_data
//   Load/store : lsb_read_req, lsb_write_req, lsb_addr, lsb_wdata, lsb_len
//                -> lsb_load_done, lsb_data, lsb_store_done
//   RAM port   : mem_din -> mem_dout, mem_a, mem_wr
//   Debug      : state_dbg (current FSM state)
// Handshake: a requester raises its *_req with stable address/data/length and
// keeps it high until the matching one-cycle *_done pulse; it drops the request
// in the pulse cycle, because the arbiter is back in IDLE then and samples again.
// modport slave is the arbiter, modport master is the requesting/RAM side.
interface mem_arbiter_if;
  import mem_arbiter_pkg::*;

  logic              rdy;
  logic              jump_wrong;
  logic              io_buffer_full;
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              lsb_read_req;
  logic              lsb_write_req;
  logic [ADDR_W-1:0] lsb_addr;
  logic [DATA_W-1:0] lsb_wdata;
  logic [1:0]        lsb_len;
  logic [7:0]        mem_din;
  logic [7:0]        mem_dout;
  logic [ADDR_W-1:0] mem_a;
  logic              mem_wr;
  logic              if_done;
  logic [DATA_W-1:0] if_data;
  logic              lsb_load_done;
  logic [DATA_W-1:0] lsb_data;
  logic              lsb_store_done;
  logic [1:0]        state_dbg;

  modport slave (
    input  rdy, jump_wrong, io_buffer_full,
    input  if_req, if_addr,
    input  lsb_read_req, lsb_write_req, lsb_addr, lsb_wdata, lsb_len,
    input  mem_din,
    output mem_dout, mem_a, mem_wr,
    output if_done, if_data, lsb_load_done, lsb_data, lsb_store_done,
    output state_dbg
  );

  modport master (
    output rdy, jump_wrong, io_buffer_full,
    output if_req, if_addr,
    output lsb_read_req, lsb_write_req, lsb_addr, lsb_wdata, lsb_len,
    output mem_din,
    input  mem_dout, mem_a, mem_wr,
    input  if_done, if_data, lsb_load_done, lsb_data, lsb_store_done,
    input  state_dbg
  );

endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: arbitrates instruction fetch and LSB load/store onto a byte-wide
// RAM port with one cycle of read latency.
// Ports:
//   clk  - clock, all state updates on the rising edge
//   rst  - synchronous active-high reset
//   bus  - mem_arbiter_if.slave (requests, RAM port, completions, state_dbg)
// Transactions are accepted only from IDLE with priority write > read > fetch.
// The accept edge registers mem_a = addr, so byte i is on the bus in cycle
// T+i. A read byte returns on mem_din one cycle later and is captured at the end
// of that cycle. Loads and fetches pulse done in T+n+1; stores pulse done in T+n.
// rdy=0 freezes every register. mem_dinnis assumed to follow the address
// registered on the last enabled edge.
module mem_arbiter
  import mem_arbiter_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  mem_arbiter_if.slave bus
);

  arb_state_e        state_q;
  logic [2:0]        cnt_q;
  logic [2:0]        n_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] buf_q;
  logic [ADDR_W-1:0] mem_a_q;
  logic [7:0]        mem_dout_q;
  logic              mem_wr_q;
  logic              if_done_q;
  logic [DATA_W-1:0] if_data_q;
  logic              lsb_load_done_q;
  logic [DATA_W-1:0] lsb_data_q;
  logic              lsb_store_done_q;

  logic [2:0]        cnt_inc;
  logic [ADDR_W-1:0] addr_next;
  logic [1:0]        cap_idx;
  logic [DATA_W-1:0] buf_merged;
  logic [7:0]        wbyte_next;

  assign cnt_inc   = cnt_q + 3'd1;
  assign addr_next = addr_q + {29'd0, cnt_inc};
  // With cnt in 1..4 the byte arriving on mem_din belongs to index cnt-1;
  // the 2-bit wrap maps cnt=4 onto byte 3.
  assign cap_idx   = cnt_q[1:0] - 2'd1;

  // Read buffer including the byte currently on mem_din. At cnt==0 no byte
  // has returned yet.
  always_comb begin
    buf_merged = buf_q;
    if (cnt_q != 3'd0) begin
      case (cap_idx)
        2'd0:    buf_merged[7:0]   = bus.mem_din;
        2'd1:    buf_merged[15:8]  = bus.mem_din;
        2'd2:    buf_merged[23:16] = bus.mem_din;
        default: buf_merged[31:24] = bus.mem_din;
      endcase
    end
  end

  // Store byte that goes out after the current one.
  always_comb begin
    case (cnt_inc[1:0])
      2'd0:    wbyte_next = wdata_q[7:0];
      2'd1:    wbyte_next = wdata_q[15:8];
      2'd2:    wbyte_next = wdata_q[23:16];
      default: wbyte_next = wdata_q[31:24];
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= ST_IDLE;
      cnt_q            <= 3'd0;
      n_q              <= 3'd0;
      addr_q           <= '0;
      wdata_q          <= '0;
      buf_q            <= '0;
      mem_a_q          <= '0;
      mem_dout_q       <= 8'd0;
      mem_wr_q         <= 1'b0;
      if_done_q        <= 1'b0;
      if_data_q        <= '0;
      lsb_load_done_q  <= 1'b0;
      lsb_data_q       <= '0;
      lsb_store_done_q <= 1'b0;
    end else if (bus.rdy) begin
      if_done_q        <= 1'b0;
      lsb_load_done_q  <= 1'b0;
      lsb_store_done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          mem_wr_q <= 1'b0;
          cnt_q    <= 3'd0;
          // Stores are committed work, so they are accepted even while a flush
          // is signalled; reads and fetches are not.
          if (bus.lsb_write_req) begin
            state_q    <= ST_STORE;
            addr_q     <= bus.lsb_addr;
            n_q        <= len_to_bytes(bus.lsb_len);
            wdata_q    <= bus.lsb_wdata;
            mem_a_q    <= bus.lsb_addr;
            mem_dout_q <= bus.lsb_wdata[7:0];
            mem_wr_q   <= !(is_io_sel(bus.lsb_addr[17:16]) && bus.io_buffer_full);
          end else if (!bus.jump_wrong) begin
            if (bus.lsb_read_req) begin
              state_q <= ST_LOAD;
              addr_q  <= bus.lsb_addr;
              n_q     <= len_to_bytes(bus.lsb_len);
              mem_a_q <= bus.lsb_addr;
              buf_q   <= '0;
            end else if (bus.if_req) begin
              state_q <= ST_FETCH;
              addr_q  <= bus.if_addr;
              n_q     <= 3'd4;
              mem_a_q <= bus.if_addr;
              buf_q   <= '0;
            end
          end
        end

        ST_FETCH, ST_LOAD: begin
          if (bus.jump_wrong) begin
            state_q <= ST_IDLE;
            cnt_q   <= 3'd0;
          end else if (cnt_q == n_q) begin
            state_q <= ST_IDLE;
            cnt_q   <= 3'd0;
            if (state_q == ST_FETCH) begin
              if_done_q <= 1'b1;
              if_data_q <= buf_merged;
            end else begin
              lsb_load_done_q <= 1'b1;
              lsb_data_q      <= buf_merged;
            end
          end else begin
            cnt_q <= cnt_inc;
            buf_q <= buf_merged;
            // After the last address mem_a simply holds.
            if (cnt_inc != n_q) mem_a_q <= addr_next;
          end
        end

        ST_STORE: begin
          // mem_wr_q=1 means byte cnt is written this cycle. Otherwise the same
          // byte is waiting on a full IO buffer and is retried.
          if (mem_wr_q) begin
            if (cnt_inc == n_q) begin
              state_q          <= ST_IDLE;
              cnt_q            <= 3'd0;
              mem_wr_q         <= 1'b0;
              lsb_store_done_q <= 1'b1;
            end else begin
              cnt_q      <= cnt_inc;
              mem_a_q    <= addr_next;
              mem_dout_q <= wbyte_next;
              mem_wr_q   <= !(is_io_sel(addr_next[17:16]) && bus.io_buffer_full);
            end
          end else begin
            mem_wr_q <= !(is_io_sel(mem_a_q[17:16]) && bus.io_buffer_full);
          end
        end

        default: begin
          state_q  <= ST_IDLE;
          cnt_q    <= 3'd0;
          mem_wr_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.mem_a          = mem_a_q;
  assign bus.mem_dout       = mem_dout_q;
  // A pending write must not reach the RAM while the core is frozen. It is
  // performed on the first enabled edge instead.
  assign bus.mem_wr         = mem_wr_q & bus.rdy;
  assign bus.if_done        = if_done_q;
  assign bus.if_data        = if_data_q;
  assign bus.lsb_load_done  = lsb_load_done_q;
  assign bus.lsb_data       = lsb_data_q;
  assign bus.lsb_store_done = lsb_store_done_q;
  assign bus.state_dbg      = state_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed bench for mem_arbiter with a byte RAM model, a
// write monitor feeding obs_q, an expected write queue exp_q and
// cycle-exact checks of the fetch, load, store, flush, stall, rdy and reset
// behaviour.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_arbiter_if bus();

  mem_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- RAM model + monitors ----------------
  logic [7:0]  ram [0:65535];
  logic [39:0] exp_q[$];
  logic [39:0] obs_q[$];
  int n_checks = 0;
  int n_pass   = 0;
  int n_if_done = 0, n_load_done = 0, n_store_done = 0;

  always @(posedge clk) begin
    if (bus.rdy) bus.mem_din <= ram[bus.mem_a[15:0]];
    if (bus.mem_wr) ram[bus.mem_a[15:0]] <= bus.mem_dout;
  end

  always @(negedge clk) begin
    if (bus.mem_wr === 1'b1) obs_q.push_back({bus.mem_a, bus.mem_dout});
    if (bus.if_done === 1'b1) n_if_done++;
    if (bus.lsb_load_done === 1'b1) n_load_done++;
    if (bus.lsb_store_done === 1'b1) n_store_done++;
    if ((bus.lsb_read_req || bus.lsb_write_req) && bus.lsb_len == 2'd3)
      $error("illegal lsb_len=3 driven");
  end

  // ---------------- driver / checker tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] exp);
    n_checks++;
    if (obs !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    else n_pass++;
  endtask

  task automatic idle_inputs();
    bus.jump_wrong     = 1'b0;
    bus.io_buffer_full = 1'b0;
    bus.if_req         = 1'b0;
    bus.if_addr        = '0;
    bus.lsb_read_req   = 1'b0;
    bus.lsb_write_req  = 1'b0;
    bus.lsb_addr       = '0;
    bus.lsb_wdata      = '0;
    bus.lsb_len        = 2'd0;
  endtask

  task automatic ram_load(input logic [15:0] a, input logic [31:0] w);
    for (int i = 0; i < 4; i++) ram[a + 16'(i)] <= w[8*i +: 8];
  endtask

  task automatic check_writes(input string tag);
    chk({tag, "_wr_count"}, 40'(obs_q.size()), 40'(exp_q.size()));
    while (exp_q.size() > 0 && obs_q.size() > 0)
      chk({tag, "_wr"}, obs_q.pop_front(), exp_q.pop_front());
    exp_q.delete();
    obs_q.delete();
  endtask

  int base;

  // ---------------- stimulus ----------------
  initial begin
    rst     = 1'b1;
    bus.rdy = 1'b1;
    idle_inputs();
    for (int i = 0; i < 65536; i++) ram[i] <= 8'h00;
    repeat (3) tick();

    chk("rst_state",      bus.state_dbg, ST_IDLE);
    chk("rst_mem_wr",     bus.mem_wr, 0);
    chk("rst_mem_a",      bus.mem_a, 0);
    chk("rst_mem_dout",   bus.mem_dout, 0);
    chk("rst_if_data",    bus.if_data, 0);
    chk("rst_lsb_data",   bus.lsb_data, 0);
    chk("rst_dones",      {bus.if_done, bus.lsb_load_done, bus.lsb_store_done}, 0);
    rst = 1'b0;
    ram_load(16'h0100, 32'h0000_0513);
    ram_load(16'h2000, 32'h0000_00F0);
    ram_load(16'h0200, 32'h1234_5678);
    ram_load(16'h3000, 32'hCAFE_F00D);
    ram_load(16'h0300, 32'hDEAD_BEEF);
    tick();
    obs_q.delete();

    // ---- word fetch from 0x100 ----
    bus.if_req = 1'b1; bus.if_addr = 32'h100;
    tick();
    chk("fetch_state", bus.state_dbg, ST_FETCH);
    chk("fetch_a0", bus.mem_a, 32'h100);
    chk("fetch_wr", bus.mem_wr, 0);
    for (int i = 1; i < 4; i++) begin
      tick();
      chk("fetch_a", bus.mem_a, 40'h100 + 40'(i));
    end
    tick();
    chk("fetch_early_done", bus.if_done, 0);
    tick();
    chk("fetch_done", bus.if_done, 1);
    chk("fetch_data", bus.if_data, 32'h0000_0513);
    chk("fetch_idle", bus.state_dbg, ST_IDLE);
    bus.if_req = 1'b0;
    tick();
    chk("fetch_done_pulse", bus.if_done, 0);
    chk("fetch_data_hold", bus.if_data, 32'h0000_0513);

    // ---- load beats fetch raised in the same cycle ----
    bus.lsb_read_req = 1'b1; bus.lsb_len = REQUIRE16; bus.lsb_addr = 32'h2000;
    bus.if_req = 1'b1; bus.if_addr = 32'h200;
    tick();
    chk("prio_state", bus.state_dbg, ST_LOAD);
    chk("prio_a0", bus.mem_a, 32'h2000);
    tick();
    chk("prio_a1", bus.mem_a, 32'h2001);
    tick();
    chk("prio_early_done", bus.lsb_load_done, 0);
    tick();
    chk("prio_load_done", bus.lsb_load_done, 1);
    chk("prio_lsb_data", bus.lsb_data, 32'h0000_00F0);
    chk("prio_no_if_done", bus.if_done, 0);
    bus.lsb_read_req = 1'b0;
    tick();
    chk("prio_fetch_state", bus.state_dbg, ST_FETCH);
    chk("prio_fetch_a0", bus.mem_a, 32'h200);
    repeat (4) tick();
    chk("prio_fetch_early", bus.if_done, 0);
    tick();
    chk("prio_fetch_done", bus.if_done, 1);
    chk("prio_fetch_data", bus.if_data, 32'h1234_5678);
    chk("prio_lsb_hold", bus.lsb_data, 32'h0000_00F0);
    bus.if_req = 1'b0;
    tick();

    // ---- byte store to IO space with buffer full for 3 cycles ----
    obs_q.delete();
    exp_q.push_back({32'h0003_0000, 8'h41});
    bus.lsb_write_req = 1'b1; bus.lsb_len = REQUIRE8;
    bus.lsb_addr = 32'h0003_0000; bus.lsb_wdata = 32'h0000_0041;
    bus.io_buffer_full = 1'b1;
    tick();
    chk("io_state", bus.state_dbg, ST_STORE);
    chk("io_stall1", bus.mem_wr, 0);
    tick();
    chk("io_stall2", bus.mem_wr, 0);
    tick();
    chk("io_stall3", bus.mem_wr, 0);
    bus.io_buffer_full = 1'b0;
    tick();
    chk("io_write", bus.mem_wr, 1);
    chk("io_dout", bus.mem_dout, 8'h41);
    chk("io_addr", bus.mem_a, 32'h0003_0000);
    chk("io_no_done_yet", bus.lsb_store_done, 0);
    tick();
    chk("io_store_done", bus.lsb_store_done, 1);
    chk("io_wr_off", bus.mem_wr, 0);
    bus.lsb_write_req = 1'b0;
    tick();
    check_writes("io");

    // ---- flush in the 2nd byte cycle of a word load ----
    base = n_load_done;
    bus.lsb_read_req = 1'b1; bus.lsb_len = REQUIRE32; bus.lsb_addr = 32'h3000;
    tick();
    chk("flush_ld_state", bus.state_dbg, ST_LOAD);
    tick();
    chk("flush_ld_a1", bus.mem_a, 32'h3001);
    bus.jump_wrong = 1'b1; bus.lsb_read_req = 1'b0;
    tick();
    chk("flush_ld_idle", bus.state_dbg, ST_IDLE);
    bus.jump_wrong = 1'b0;
    repeat (5) tick();
    chk("flush_ld_no_done", 40'(n_load_done - base), 0);
    chk("flush_ld_data_hold", bus.lsb_data, 32'h0000_00F0);

    // ---- a fetch raised together with jump_wrong waits ----
    bus.if_req = 1'b1; bus.if_addr = 32'h100; bus.jump_wrong = 1'b1;
    tick();
    chk("jw_blocks_fetch", bus.state_dbg, ST_IDLE);
    bus.jump_wrong = 1'b0;
    tick();
    chk("jw_then_fetch", bus.state_dbg, ST_FETCH);
    bus.jump_wrong = 1'b1; bus.if_req = 1'b0;
    tick();
    chk("jw_abort_fetch", bus.state_dbg, ST_IDLE);
    bus.jump_wrong = 1'b0;
    tick();

    // ---- halfword store to 0x400 is not aborted by jump_wrong ----
    obs_q.delete();
    exp_q.push_back({32'h400, 8'hFE});
    exp_q.push_back({32'h401, 8'hCA});
    bus.lsb_write_req = 1'b1; bus.lsb_len = REQUIRE16;
    bus.lsb_addr = 32'h400; bus.lsb_wdata = 32'hBEEF_CAFE; bus.jump_wrong = 1'b1;
    tick();
    chk("st_jw_state", bus.state_dbg, ST_STORE);
    chk("st_jw_b0", {bus.mem_wr, bus.mem_a, bus.mem_dout}, {1'b1, 32'h400, 8'hFE});
    tick();
    chk("st_jw_b1", {bus.mem_wr, bus.mem_a, bus.mem_dout}, {1'b1, 32'h401, 8'hCA});
    tick();
    chk("st_jw_done", bus.lsb_store_done, 1);
    chk("st_jw_idle", bus.state_dbg, ST_IDLE);
    bus.lsb_write_req = 1'b0; bus.jump_wrong = 1'b0;
    tick();
    check_writes("st_jw");
    chk("st_jw_ram", {ram[16'h400], ram[16'h401]}, 16'hFECA);

    // ---- rdy low for 2 cycles mid-fetch ----
    bus.if_req = 1'b1; bus.if_addr = 32'h300;
    tick();
    chk("rdy_a0", bus.mem_a, 32'h300);
    tick();
    chk("rdy_a1", bus.mem_a, 32'h301);
    bus.rdy = 1'b0;
    tick();
    chk("rdy_frz1", {bus.state_dbg, bus.mem_a}, {ST_FETCH, 32'h301});
    tick();
    chk("rdy_frz2", {bus.state_dbg, bus.mem_a}, {ST_FETCH, 32'h301});
    bus.rdy = 1'b1;
    tick();
    chk("rdy_a2", bus.mem_a, 32'h302);
    tick();
    chk("rdy_a3", bus.mem_a, 32'h303);
    tick();
    chk("rdy_early_done", bus.if_done, 0);
    tick();
    chk("rdy_done", bus.if_done, 1);
    chk("rdy_data", bus.if_data, 32'hDEAD_BEEF);
    bus.if_req = 1'b0;
    tick();

    // ---- rdy gates a store write, then reset aborts the store ----
    obs_q.delete();
    exp_q.push_back({32'h500, 8'h44});
    exp_q.push_back({32'h501, 8'h33});
    base = n_store_done;
    bus.lsb_write_req = 1'b1; bus.lsb_len = REQUIRE32;
    bus.lsb_addr = 32'h500; bus.lsb_wdata = 32'h1122_3344;
    tick();
    chk("rst_st_b0", {bus.mem_wr, bus.mem_a, bus.mem_dout}, {1'b1, 32'h500, 8'h44});
    bus.rdy = 1'b0;
    #1;
    chk("rdy_forces_wr0", bus.mem_wr, 0);
    tick();
    chk("rdy_st_frozen", {bus.mem_a, bus.mem_dout}, {32'h500, 8'h44});
    bus.rdy = 1'b1;
    #1;
    chk("rdy_st_resume_wr", bus.mem_wr, 1);
    tick();
    chk("rst_st_b1", {bus.mem_wr, bus.mem_a, bus.mem_dout}, {1'b1, 32'h501, 8'h33});
    rst = 1'b1; bus.lsb_write_req = 1'b0;
    tick();
    chk("rst_st_wr0", bus.mem_wr, 0);
    chk("rst_st_idle", bus.state_dbg, ST_IDLE);
    chk("rst_st_mem_a", bus.mem_a, 0);
    rst = 1'b0;
    repeat (3) tick();
    chk("rst_st_no_done", 40'(n_store_done - base), 0);
    check_writes("rst_st");
    chk("rst_st_ram_tail", {ram[16'h502], ram[16'h503]}, 16'h0000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 clk  in  1  system clock; all state updates on rising edge.
REQ-002 rst  in  1  reset, synchronous, active-high.
REQ-003 rdy  in  1  global enable; low freezes all state and registered outputs, with mem_wr forced 0.
REQ-004 jump_wrong  in  1  mispredict flush.
REQ-005 io_buffer_full  in  1  UART buffer full; stalls writes to IO space.
REQ-006 if_req  in  1, if_addr  in  32  instruction fetch request (always 4 bytes); held until if_done.
REQ-007 lsb_read_req  in  1, lsb_write_req  in  1  LSB load/store request; held until matching done.
REQ-008 lsb_addr  in  32, lsb_wdata  in  32, lsb_len  in  2  LSB address, store data, length (0=byte, 1=half, 2=word; 3 illegal).
REQ-009 mem_din  in  8  RAM read byte, valid one cycle after its address.
REQ-010 mem_dout  out  8, mem_a  out  32, mem_wr  out  1  RAM port (mem_wr 1=write), all registered.
REQ-011 if_done  out  1, if_data  out  32  one-cycle fetch completion pulse and instruction.
REQ-012 lsb_load_done  out  1, lsb_data  out  32  one-cycle load completion pulse and zero-extended raw data.
REQ-013 lsb_store_done  out  1  one-cycle store completion pulse.

Function
REQ-014 FSM states: IDLE, FETCH, LOAD, STORE; counter cnt 0..4 and byte count n (1/2/4) held per transaction.
REQ-015 Requests are sampled only in IDLE. Fixed priority: lsb_write_req > lsb_read_req > if_req. No preemption once a transaction starts.
REQ-016 Acceptance edge T latches addr, n, and wdata. Byte i (i=0..n-1) drives mem_a=addr+i during cycle T+i; increment is 32-bit wrap-around.
REQ-017 LOAD/FETCH: mem_wr=0. Byte from cycle T+i is captured from mem_din in cycle T+i+1 into bits [8i+7:8i]. Unused upper bytes are 0.
REQ-018 LOAD/FETCH: done pulse and data are valid in cycle T+n+1. FSM returns to IDLE on that edge, so the earliest next acceptance is cycle T+n+2.
REQ-019 STORE: mem_wr=1 and mem_dout=wdata[8i+7:8i] in cycle T+i. lsb_store_done pulses in cycle T+n, then IDLE.
REQ-020 IO stall: if addr[17:16]==2'b11 and io_buffer_full=1 in a STORE byte cycle:
  - mem_wr=0 and the byte index holds.
  - The byte is issued in the first cycle io_buffer_full=0.
REQ-021 Done pulses are mutually exclusive and deassert the cycle after assertion. if_data and lsb_data hold their value until the next completion.
REQ-022 Flush: jump_wrong=1 with rdy=1 aborts FETCH and LOAD. The FSM goes to IDLE next edge, no done pulse is emitted, and mem_wr=0.
REQ-023 STORE is never aborted by jump_wrong; a store is committed by definition and completes with its done pulse.
REQ-024 A request arriving together with jump_wrong is not accepted that cycle, except lsb_write_req.
REQ-025 When idle: mem_wr=0, and mem_a holds its last value.
REQ-026 lsb_len=3 is treated as word; a bench assertion flags it.

Reset
REQ-027 On rst: state=IDLE, cnt=0, and mem_wr, if_done, lsb_load_done, lsb_store_done are 0.
REQ-028 On rst: mem_a, mem_dout, if_data, lsb_data are 0.
REQ-029 rst mid-transaction (any state, including STORE) aborts immediately, with no done pulse and no further RAM write.

Structure
REQ-030 Shared define package holds:
  - Length codes REQUIRE8/16/32 (0/1/2) and the IO address match (bits[17:16]==2'b11, i.e. 0x30000).
  - FSM state encodings and the 32-bit data/address width macros.
REQ-031 Single module, no sub-module; the byte shift/assemble logic is inline.

Verification
REQ-032 Fetch: if_req=1, if_addr=0x100, RAM[0x100..0x103]=13,05,00,00 -> mem_a 0x100..0x103 in cycles T..T+3, if_done in T+5 with if_data=0x00000513.
REQ-033 Priority: lsb_read_req(len=1, addr=0x2000, byte 0xF0) and if_req raised the same cycle -> load served first, lsb_data=0x000000F0, then fetch starts.
REQ-034 Store with IO stall: lsb_write_req, addr=0x30000, len=0, wdata=0x41, io_buffer_full high for 3 cycles -> mem_wr=0 for 3 cycles, then one write of 0x41, then lsb_store_done.
REQ-035 Flush: jump_wrong=1 in the 2nd byte cycle of a word load -> no lsb_load_done, IDLE next edge. A jump_wrong during a halfword store to 0x400 does not abort it: both bytes are written and lsb_store_done pulses.
REQ-036 rdy gating and reset: rdy=0 for 2 cycles mid-fetch -> state and mem_a frozen, fetch completes 2 cycles late with correct data. rst mid-store -> mem_wr=0 next cycle, no done pulse.
